// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel valid/ready arbiter/mux with a single registered
// output stage.
//
// Parameters
//   WIDTH    : data bits per channel
//   CHANNELS : number of input channels (2..16)
//   SEL_W    : channel index width, equal to clog2(CHANNELS)
//
// Ports
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   mode       : 00 manual (sel), 01 fixed priority (lowest index), 1x round-robin
//   sel        : manual-mode channel index
//   in_valid   : per-channel valid
//   in_last    : per-channel end-of-packet flag
//   in_data    : channel i occupies bits [i*WIDTH +: WIDTH]
//   in_ready   : per-channel ready, one-hot or zero
//   out_valid  : output register holds a beat
//   out_data   : registered data
//   out_last   : registered last flag
//   out_chan   : source channel of the current output beat
//   out_ready  : downstream accept
//   locked     : a packet lock is active

module mux_arb_n_lane #(
  parameter int WIDTH = 8
) (
  input  logic             hit_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);
  // Masked contribution of one channel to the AND-OR output mux, so data
  // from an ungranted channel never reaches the output register.
  assign ready_o = hit_i;
  assign data_o  = data_i & {WIDTH{hit_i}};
  assign last_o  = last_i & hit_i;
endmodule

module mux_arb_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready,
  output logic                      locked
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;

  lock_e                          state_q;
  logic [SEL_W-1:0]               lock_chan_q;
  logic [SEL_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic                           out_valid_q, out_valid_d;
  logic [WIDTH-1:0]               out_data_q, out_data_d;
  logic                           out_last_q, out_last_d;
  logic [SEL_W-1:0]               out_chan_q, out_chan_d;

  logic                           load_en;
  logic                           grant_vld;
  logic [SEL_W-1:0]               grant_idx;
  logic                           xfer;
  logic [CHANNELS-1:0]            hit;
  logic [CHANNELS-1:0][WIDTH-1:0] data_m;
  logic [CHANNELS-1:0]            last_m;
  logic [WIDTH-1:0]               mux_data;
  logic                           mux_last;

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign load_en = rst_n && (!out_valid_q || out_ready);

  // Grant selection. Comparisons are against the loop constant so an
  // out-of-range sel or pointer simply never matches.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (state_q == LOCKED) begin
      for (int i = 0; i < CHANNELS; i++)
        if (in_valid[i] && SEL_W'(i) == lock_chan_q) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
    end else begin
      case (mode)
        2'b00: begin
          for (int i = 0; i < CHANNELS; i++)
            if (in_valid[i] && SEL_W'(i) == sel) begin
              grant_vld = 1'b1;
              grant_idx = SEL_W'(i);
            end
        end
        2'b01: begin
          // Descending scan: the last hit written is the lowest index.
          for (int i = CHANNELS - 1; i >= 0; i--)
            if (in_valid[i]) begin
              grant_vld = 1'b1;
              grant_idx = SEL_W'(i);
            end
        end
        default: begin
          // Round-robin as two descending scans: the lowest valid index
          // below the pointer (the wrapped part), then overridden by the
          // lowest valid index at or above the pointer if one exists.
          for (int i = CHANNELS - 1; i >= 0; i--)
            if (in_valid[i] && SEL_W'(i) < rr_ptr_q) begin
              grant_vld = 1'b1;
              grant_idx = SEL_W'(i);
            end
          for (int i = CHANNELS - 1; i >= 0; i--)
            if (in_valid[i] && SEL_W'(i) >= rr_ptr_q) begin
              grant_vld = 1'b1;
              grant_idx = SEL_W'(i);
            end
        end
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign hit[g] = load_en && grant_vld && (grant_idx == SEL_W'(g));
    mux_arb_n_lane #(.WIDTH(WIDTH)) u_lane (
      .hit_i   (hit[g]),
      .data_i  (in_data[g*WIDTH +: WIDTH]),
      .last_i  (in_last[g]),
      .ready_o (in_ready[g]),
      .data_o  (data_m[g]),
      .last_o  (last_m[g])
    );
  end

  always_comb begin
    mux_data = '0;
    mux_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      mux_data = mux_data | data_m[i];
      mux_last = mux_last | last_m[i];
    end
  end

  assign xfer = |hit;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = mux_data;
        out_last_d = mux_last;
        out_chan_d = grant_idx;
      end
    end
    // Pointer advances on packet completion in every mode so a later switch
    // to round-robin resumes fairly.
    if (xfer && mux_last)
      rr_ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      lock_chan_q <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
      if (xfer) begin
        case (state_q)
          UNLOCKED: if (!mux_last) begin
            state_q     <= LOCKED;
            lock_chan_q <= grant_idx;
          end
          LOCKED: if (mux_last) state_q <= UNLOCKED;
          default: state_q <= UNLOCKED;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_mux_arb_n.sv
module tb_mux_arb_n;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready, locked;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;

  logic [1:0]  mode3, sel3;
  logic [2:0]  in_valid3, in_last3, in_ready3;
  logic [23:0] in_data3;
  logic        out_valid3, out_last3, locked3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready),
    .locked(locked)
  );

  mux_arb_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_last(in_last3), .in_data(in_data3),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
    .out_last(out_last3), .out_chan(out_chan3), .out_ready(1'b1),
    .locked(locked3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int ch, input logic [7:0] v);
    in_data[ch*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b01; sel = 2'd0; in_valid = 4'b0110; in_last = 4'b1111;
    in_data = 32'h0; out_ready = 1'b1;
    mode3 = 2'b00; sel3 = 2'd0; in_valid3 = 3'b000; in_last3 = 3'b111; in_data3 = 24'h0;
    setd(1, 8'h11); setd(2, 8'h22);
    tick(); tick();

    // Reset state, ready held low under reset
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_locked", locked, 0);
    chk("rst_in_ready", in_ready, 4'b0000);

    // Fixed priority
    rst_n = 1'b1; #1;
    chk("fix_ready_ch1", in_ready, 4'b0010);
    tick();
    chk("fix_valid1", out_valid, 1);
    chk("fix_data1", out_data, 8'h11);
    chk("fix_chan1", out_chan, 1);
    in_valid = 4'b0100; #1;
    chk("fix_ready_ch2", in_ready, 4'b0100);
    tick();
    chk("fix_data2", out_data, 8'h22);
    chk("fix_chan2", out_chan, 2);
    in_valid = 4'b0000;
    tick();
    chk("fix_idle_valid", out_valid, 0);
    chk("fix_idle_hold", out_data, 8'h22);

    // Round-robin, single-beat packets
    do_reset();
    mode = 2'b10; in_valid = 4'b1111; in_last = 4'b1111;
    for (int i = 0; i < 4; i++) setd(i, 8'hA0 + 8'(i));
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_chan", out_chan, k % 4);
      chk("rr_data", out_data, 8'hA0 + (k % 4));
    end

    // Round-robin with a 3-beat locked packet on ch2
    do_reset();
    mode = 2'b10; in_valid = 4'b0010; in_last = 4'b1111; setd(1, 8'h31);
    tick();
    chk("lk_pre_chan", out_chan, 1);
    in_valid = 4'b1101; in_last = 4'b1011;
    setd(0, 8'h0F); setd(2, 8'hB1); setd(3, 8'h3F); #1;
    chk("lk_ready_ch2", in_ready, 4'b0100);
    tick();
    chk("lk_b1_chan", out_chan, 2);
    chk("lk_b1_data", out_data, 8'hB1);
    chk("lk_b1_locked", locked, 1);
    mode = 2'b01; setd(2, 8'hB2); #1;
    chk("lk_mode_ignored", in_ready, 4'b0100);
    tick();
    chk("lk_b2_chan", out_chan, 2);
    chk("lk_b2_data", out_data, 8'hB2);
    mode = 2'b10; setd(2, 8'hB3); in_last = 4'b1111;
    tick();
    chk("lk_b3_chan", out_chan, 2);
    chk("lk_b3_data", out_data, 8'hB3);
    chk("lk_b3_unlocked", locked, 0);
    chk("lk_next_ready_ch3", in_ready, 4'b1000);
    tick();
    chk("lk_next_chan", out_chan, 3);
    chk("lk_next_data", out_data, 8'h3F);

    // Backpressure
    do_reset();
    mode = 2'b01; in_valid = 4'b0001; in_last = 4'b1111; setd(0, 8'h5A);
    tick();
    chk("bp_data0", out_data, 8'h5A);
    out_ready = 1'b0; setd(0, 8'h6B);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready_low", in_ready, 4'b0000);
      tick();
      chk("bp_hold_data", out_data, 8'h5A);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1; #1;
    chk("bp_ready_back", in_ready, 4'b0001);
    tick();
    chk("bp_next_data", out_data, 8'h6B);
    in_valid = 4'b0000;
    tick();
    chk("bp_no_dup", out_valid, 0);

    // Manual select, 4 channels and out-of-range on 3 channels
    do_reset();
    mode = 2'b00; sel = 2'd3; in_valid = 4'b1111; setd(3, 8'hC3); setd(0, 8'h01);
    in_valid3 = 3'b111; in_data3 = 24'h332211; sel3 = 2'd0; #1;
    chk("man_ready_ch3", in_ready, 4'b1000);
    tick();
    chk("man_data", out_data, 8'hC3);
    chk("man_chan", out_chan, 3);
    chk("man3_valid", out_valid3, 1);
    chk("man3_data", out_data3, 8'h11);
    sel3 = 2'd3; #1;
    chk("man3_oor_ready", in_ready3, 3'b000);
    tick();
    chk("man3_oor_valid", out_valid3, 0);
    in_valid3 = 3'b000;

    // Reset mid-packet
    mode = 2'b10; in_valid = 4'b0100; in_last = 4'b1111;
    tick();   // ch2 single beat: pointer moves to 3
    in_valid = 4'b0010; in_last = 4'b0000; setd(1, 8'h71);
    tick();
    chk("mid_locked", locked, 1);
    chk("mid_chan", out_chan, 1);
    rst_n = 1'b0; in_valid = 4'b1111; in_last = 4'b1111;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_ready", in_ready, 4'b0000);
    rst_n = 1'b1; #1;
    chk("mid_rr_ptr0", in_ready, 4'b0001);
    tick();
    chk("mid_after_chan", out_chan, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-channel successor to the 4:1 combinational mux. Selects one of CHANNELS valid/ready input streams and drives a single registered output stage.
- Select mode is chosen at runtime: manual select, fixed priority, or round-robin.
- Packet locking holds the grant on one channel until a beat with last=1 transfers.
- Sits between multiple producers and a single downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels, 2..16.
- SEL_W, 2, select/index width; must equal clog2(CHANNELS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- mode  input  2  00 = manual, 01 = fixed priority (lowest index wins), 10 and 11 = round-robin.
- sel  input  SEL_W  manual-mode channel index.
- in_valid  input  CHANNELS  per-channel valid.
- in_last  input  CHANNELS  per-channel end-of-packet flag.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  per-channel ready, one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered last flag.
- out_chan  output  SEL_W  source channel of the current output beat.
- out_ready  input  1  downstream accept.
- locked  output  1  a packet lock is active.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_last=0, out_chan=0, locked=0, rr_ptr=0, lock_chan=0. in_ready is 0 while rst_n=0.
- Load enable: load_en = !out_valid || out_ready. This gives full throughput, one beat per cycle.
- Grant is combinational from in_valid, mode, sel, rr_ptr, locked and lock_chan. At most one grant.
  - Manual: grant = sel if in_valid[sel]. If sel >= CHANNELS, there is no grant.
  - Fixed: grant = the lowest i with in_valid[i].
  - Round-robin: grant = the first valid i searching rr_ptr, rr_ptr+1, … with wrap modulo CHANNELS.
  - Locked: grant = lock_chan if in_valid[lock_chan], otherwise no grant. mode and sel are ignored while locked.
- in_ready[i] = load_en && grant==i. A transfer occurs on in_valid[i] && in_ready[i].
- On a transfer, at the next edge:
  - out_data = the granted channel's data.
  - out_last = in_last[i].
  - out_chan = i.
  - out_valid = 1.
  - Latency is 1 cycle from input transfer to out_valid.
- On load_en with no transfer: out_valid -> 0 at the next edge. out_data, out_last and out_chan hold their values.
- While out_valid && !out_ready, all output registers hold and every in_ready is 0.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED on a transfer with in_last=0; lock_chan = i.
  - LOCKED -> UNLOCKED on a transfer from lock_chan with in_last=1.
  - A transfer with in_last=1 in UNLOCKED stays UNLOCKED (single-beat packet).
  - locked reflects the state register.
- rr_ptr updates only when a transfer completes a packet (in_last=1): rr_ptr = (i+1) mod CHANNELS, wrapping from CHANNELS-1 to 0. The update happens in every mode, so switching to round-robin continues fairly.
- A mode or sel change while UNLOCKED takes effect in the same cycle, because grant is combinational.
- Reset mid-packet clears the lock immediately. The in-flight output beat is dropped (out_valid=0).
- in_valid on an ungranted channel has no effect. Its data is never sampled.

Test Plan:
- Reset, then release with mode=01, in_valid=0110, in_last=1111, data ch1=0x11, ch2=0x22, out_ready=1 -> in_ready=0010; next cycle out_data=0x11, out_chan=1, out_valid=1. Ch1 deasserts, then ch2 is granted; out_data=0x22 the following cycle.
- mode=10, all four channels valid with single-beat packets (last=1), out_ready=1 -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles; rr_ptr wraps 3->0.
- mode=10, ch2 sends a 3-beat packet (last=0,0,1) while ch0 and ch3 are held valid -> locked=1 after beat 1. out_chan=2 for 3 consecutive beats, then ch3 is granted next (rr_ptr=3); locked=0 after the last beat.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, data 0x5A -> out_data holds 0x5A and in_ready=0000. On out_ready=1 the next beat loads the following cycle with no beat lost or duplicated.
- Manual mode=00 with sel=3, in_valid=1111, ch3 data 0xC3 -> only in_ready[3] rises and out_data=0xC3. With CHANNELS=3 and sel=3 -> in_ready=000 and out_valid falls to 0.
- Reset asserted mid-packet (locked=1, out_valid=1) -> on the next edge out_valid=0, locked=0, rr_ptr=0. With mode=10 after release, ch0 is granted first.
